// File: rtl/mask_bit_scanner_pkg.sv
// mask_bit_scanner_pkg: scanner state encoding and default mask width
package mask_bit_scanner_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
  localparam int WIDTH_DEFAULT = 32;
endpackage

// File: rtl/mask_bit_scanner_priority_encoder.sv
// priority_encoder: index of the lowest set bit (highest under MASK_BIT_SCANNER_MSB_FIRST_EN)
module priority_encoder #(
  parameter  int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  always_comb begin
    o_idx = '0;
`ifdef MASK_BIT_SCANNER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) if (i_vec[i]) o_idx = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--) if (i_vec[i]) o_idx = IDX_W'(i);
`endif
  end
  assign o_any = |i_vec;
endmodule

// File: rtl/mask_bit_scanner.sv
// mask_bit_scanner: emits the set-bit indices of a mask one per beat (MASK_BIT_SCANNER_MSB_FIRST_EN: MSB first)
module mask_bit_scanner
  import mask_bit_scanner_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_none
);
  state_t           r_state;
  logic [WIDTH-1:0] r_mask;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic             r_none;
  logic             w_accept;
  logic             w_xfer;
  logic             w_scan_nxt;
  logic             w_last_nxt;
  logic             w_enc_any;
  logic [IDX_W-1:0] w_enc_idx;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_mask_nxt;

`ifdef MASK_BIT_SCANNER_MSB_FIRST_EN
  assign w_clr = r_mask & ~(WIDTH'(1) << r_idx);
`else
  assign w_clr = r_mask & (r_mask - WIDTH'(1));
`endif

  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_xfer     = (r_state == SCAN) && out_ready;
  assign w_mask_nxt = w_accept ? in_mask : w_xfer ? w_clr : r_mask;
  assign w_scan_nxt = w_accept || ((r_state == SCAN) && !(w_xfer && r_last));
  assign w_last_nxt = (w_mask_nxt & (w_mask_nxt - WIDTH'(1))) == '0;

  // Outputs are precomputed from the next mask so they come straight from flops
  priority_encoder #(.WIDTH(WIDTH)) u_penc (
    .i_vec(w_mask_nxt),
    .o_idx(w_enc_idx),
    .o_any(w_enc_any)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_none  <= 1'b0;
    end else begin
      r_state <= w_scan_nxt ? SCAN : IDLE;
      r_mask  <= w_mask_nxt;
      r_idx   <= w_scan_nxt ? w_enc_idx : '0;
      r_last  <= w_scan_nxt && w_last_nxt;
      r_none  <= w_scan_nxt && !w_enc_any;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == SCAN);
  assign out_index = r_idx;
  assign out_last  = r_last;
  assign out_none  = r_none;
endmodule
